// File: rtl/ram_dual_port_arbiter_pkg.sv
// Shared definitions for the dual-port RAM arbiter: FSM state encoding and requester IDs.
package ram_dual_port_arbiter_pkg;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer only advances on contested grants.
module rr_arbiter_2
  import ram_dual_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;  // side that wins the next contested cycle

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      unique case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          gnt[ptr_q] = 1'b1;
          ptr_d      = ~ptr_q;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'(REQ_A);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_dual_port_arbiter.sv
// Shares one simple dual-port RAM between requesters A and B with per-port round-robin,
// tagged read return, write->read bypass and a full-array clear sweep.
module ram_dual_port_arbiter
  import ram_dual_port_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 6,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    BYPASS         = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  a_wr_req,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_wr_gnt,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  a_rd_gnt,
  output logic                  a_rd_valid,
  input  logic                  b_wr_req,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_wr_gnt,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  b_rd_gnt,
  output logic                  b_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  run_en;
  logic [1:0]            wr_gnt, rd_gnt;
  logic                  wr_any, rd_any;
  logic [1:0]            rd_own_q;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  // A clear request takes priority over any grant in the same cycle.
  assign run_en = resetn && (state_q == ST_RUN) && !clr_start;

  rr_arbiter_2 u_wr_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({b_wr_req, a_wr_req}),
    .en     (run_en),
    .gnt    (wr_gnt)
  );

  rr_arbiter_2 u_rd_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({b_rd_req, a_rd_req}),
    .en     (run_en),
    .gnt    (rd_gnt)
  );

  assign a_wr_gnt   = wr_gnt[REQ_A];
  assign b_wr_gnt   = wr_gnt[REQ_B];
  assign a_rd_gnt   = rd_gnt[REQ_A];
  assign b_rd_gnt   = rd_gnt[REQ_B];
  assign wr_any     = |wr_gnt;
  assign rd_any     = |rd_gnt;
  assign busy       = resetn && (state_q == ST_CLEAR);
  assign a_rd_valid = rd_own_q[REQ_A];
  assign b_rd_valid = rd_own_q[REQ_B];
  assign rd_data    = byp_sel_q ? byp_data_q : ram_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end else if (clr_start) begin
      state_d = ST_CLEAR;
    end
  end

  always_comb begin
    ram_we         = 1'b0;
    ram_write_addr = a_wr_addr;
    ram_data       = a_wr_data;
    if (state_q == ST_CLEAR) begin
      ram_we         = resetn;
      ram_write_addr = cnt_q;
      ram_data       = CLEAR_VALUE;
    end else begin
      ram_we = wr_any;
      if (wr_gnt[REQ_B]) begin
        ram_write_addr = b_wr_addr;
        ram_data       = b_wr_data;
      end
    end
  end

  // Read address holds its last value when no read is granted.
  always_comb begin
    ram_read_addr = rd_addr_q;
    if (rd_gnt[REQ_B])      ram_read_addr = b_rd_addr;
    else if (rd_gnt[REQ_A]) ram_read_addr = a_rd_addr;
  end

  assign byp_sel_d = BYPASS && rd_any && wr_any && (ram_write_addr == ram_read_addr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q      <= '0;
      rd_own_q   <= '0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_own_q  <= rd_gnt;
      byp_sel_q <= byp_sel_d;
      rd_addr_q <= ram_read_addr;
      if (byp_sel_d) byp_data_q <= ram_data;
    end
  end

endmodule

// File: tb/tb_ram_dual_port_arbiter.sv
// Randomised scoreboard bench for ram_dual_port_arbiter with a behavioural RAM and reference model.
module tb_ram_dual_port_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam bit BYP   = 1'b1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          clr_start;
  logic          busy;
  logic          a_wr_req, a_wr_gnt, a_rd_req, a_rd_gnt, a_rd_valid;
  logic          b_wr_req, b_wr_gnt, b_rd_req, b_rd_gnt, b_rd_valid;
  logic [AW-1:0] a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
  logic [DW-1:0] a_wr_data, b_wr_data, rd_data;
  logic [DW-1:0] ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic          ram_we;

  ram_dual_port_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (8'h00),
    .BYPASS         (BYP)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .clr_start      (clr_start),
    .busy           (busy),
    .a_wr_req       (a_wr_req),
    .a_wr_addr      (a_wr_addr),
    .a_wr_data      (a_wr_data),
    .a_wr_gnt       (a_wr_gnt),
    .a_rd_req       (a_rd_req),
    .a_rd_addr      (a_rd_addr),
    .a_rd_gnt       (a_rd_gnt),
    .a_rd_valid     (a_rd_valid),
    .b_wr_req       (b_wr_req),
    .b_wr_addr      (b_wr_addr),
    .b_wr_data      (b_wr_data),
    .b_wr_gnt       (b_wr_gnt),
    .b_rd_req       (b_rd_req),
    .b_rd_addr      (b_rd_addr),
    .b_rd_gnt       (b_rd_gnt),
    .b_rd_valid     (b_rd_valid),
    .rd_data        (rd_data),
    .ram_data       (ram_data),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_we         (ram_we),
    .ram_q          (ram_q)
  );

  always #5 clk = ~clk;

  // Physical RAM: registered read, read-before-write.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    ram_q <= ram_mem[ram_read_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          own;   // 0 = A, 1 = B
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left;
  logic          wr_turn, rd_turn;  // who wins the next contested cycle (0 = A)
  logic [AW-1:0] last_raddr;
  logic          g_awr, g_bwr, g_ard, g_brd;
  logic [1:0]    ew, er;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  exp_t          e;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_gnt", {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}, 0);
      chk("rst_valid", {a_rd_valid, b_rd_valid}, 0);
      chk("rst_we", ram_we, 0);
      clear_left = DEPTH;
      wr_turn    = 1'b0;
      rd_turn    = 1'b0;
      last_raddr = '0;
      sb.delete();
      {g_awr, g_bwr, g_ard, g_brd} = '0;
    end else begin
      ew = 2'b00;
      er = 2'b00;
      if (clear_left > 0) begin
        chk("busy_clear", busy, 1);
        chk("gnt_in_clear", {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}, 0);
        chk("clr_we", ram_we, 1);
        chk("clr_addr", ram_write_addr, DEPTH - clear_left);
        chk("clr_data", ram_data, 0);
        chk("raddr_hold_clr", ram_read_addr, last_raddr);
        ref_mem[DEPTH - clear_left] = '0;
        clear_left--;
      end else begin
        chk("busy_run", busy, 0);
        if (!clr_start) begin
          if (a_wr_req && b_wr_req) begin
            ew = wr_turn ? 2'b10 : 2'b01;
            wr_turn = ~wr_turn;
          end else ew = {b_wr_req, a_wr_req};
          if (a_rd_req && b_rd_req) begin
            er = rd_turn ? 2'b10 : 2'b01;
            rd_turn = ~rd_turn;
          end else er = {b_rd_req, a_rd_req};
        end
        chk("wr_gnt", {b_wr_gnt, a_wr_gnt}, ew);
        chk("rd_gnt", {b_rd_gnt, a_rd_gnt}, er);
        chk("we", ram_we, |ew);
        wa = ew[1] ? b_wr_addr : a_wr_addr;
        wd = ew[1] ? b_wr_data : a_wr_data;
        if (|ew) begin
          chk("waddr", ram_write_addr, wa);
          chk("wdata", ram_data, wd);
        end
        if (|er) begin
          ra = er[1] ? b_rd_addr : a_rd_addr;
          chk("raddr", ram_read_addr, ra);
          e.own  = er[1];
          e.data = (BYP && (|ew) && wa == ra) ? wd : ref_mem[ra];
          e.cyc  = cyc;
          sb.push_back(e);
          last_raddr = ra;
        end else begin
          chk("raddr_hold", ram_read_addr, last_raddr);
        end
        if (|ew) ref_mem[wa] = wd;
        if (clr_start) clear_left = DEPTH;
      end
      {g_bwr, g_awr} = ew;
      {g_brd, g_ard} = er;
    end
  end

  // Read-return monitor
  exp_t m;
  always @(negedge clk) begin
    if (resetn) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc - 1) begin
        m = sb.pop_front();
        chk("a_rd_valid", a_rd_valid, !m.own);
        chk("b_rd_valid", b_rd_valid, m.own);
        chk("rd_data", rd_data, m.data);
      end else begin
        chk("no_valid", {a_rd_valid, b_rd_valid}, 0);
      end
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Drop granted requests; in random mode also raise new ones and occasional clears.
  task automatic drive(input bit rnd);
    if (g_awr) a_wr_req = 1'b0;
    if (g_bwr) b_wr_req = 1'b0;
    if (g_ard) a_rd_req = 1'b0;
    if (g_brd) b_rd_req = 1'b0;
    clr_start = rnd && ($urandom_range(0, 149) == 0);
    if (rnd) begin
      if (!a_wr_req && $urandom_range(0, 2) != 0) begin
        a_wr_req = 1'b1; a_wr_addr = rnd_addr(); a_wr_data = DW'($urandom);
      end
      if (!b_wr_req && $urandom_range(0, 2) != 0) begin
        b_wr_req = 1'b1; b_wr_addr = rnd_addr(); b_wr_data = DW'($urandom);
      end
      if (!a_rd_req && $urandom_range(0, 2) != 0) begin
        a_rd_req = 1'b1; a_rd_addr = rnd_addr();
      end
      if (!b_rd_req && $urandom_range(0, 2) != 0) begin
        b_rd_req = 1'b1; b_rd_addr = rnd_addr();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit rnd);
    step();
    drive(rnd);
  endtask

  initial begin
    resetn = 1'b0; clr_start = 1'b0;
    a_wr_req = 1'b1; a_wr_addr = 6'h05; a_wr_data = 8'h11;
    b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    a_rd_req = 1'b0; a_rd_addr = '0; b_rd_req = 1'b0; b_rd_addr = '0;
    // Reset, then the automatic sweep with a write held pending
    repeat (3) step();
    resetn = 1'b1;
    repeat (70) tick(1'b0);

    // Contested writes held for four cycles
    a_wr_req = 1'b1; b_wr_req = 1'b1; a_wr_addr = 6'h01; b_wr_addr = 6'h02;
    for (int i = 0; i < 4; i++) begin
      a_wr_data = DW'(8'h20 + i); b_wr_data = DW'(8'h30 + i);
      step();
    end
    a_wr_req = 1'b0; b_wr_req = 1'b0;
    step();

    // Write then read the same address
    a_wr_req = 1'b1; a_wr_addr = 6'h10; a_wr_data = 8'h5A;
    tick(1'b0);
    a_rd_req = 1'b1; a_rd_addr = 6'h10;
    repeat (3) tick(1'b0);

    // Same-cycle write and read of one address
    a_wr_req = 1'b1; a_wr_addr = 6'h07; a_wr_data = 8'h33;
    b_rd_req = 1'b1; b_rd_addr = 6'h07;
    repeat (3) tick(1'b0);

    // Clear while reads are held
    a_rd_req = 1'b1; a_rd_addr = 6'h10; b_rd_req = 1'b1; b_rd_addr = 6'h01;
    tick(1'b0);
    clr_start = 1'b1;
    repeat (70) tick(1'b0);

    // Reset during a sweep at address 20
    a_wr_req = 1'b1; a_wr_addr = 6'h09; a_wr_data = 8'h77;
    clr_start = 1'b1;
    repeat (21) tick(1'b0);
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_gnt", {a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}, 0);
    chk("abort_valid", {a_rd_valid, b_rd_valid}, 0);
    chk("abort_we", ram_we, 0);
    repeat (2) tick(1'b0);
    resetn = 1'b1;
    repeat (70) tick(1'b0);

    repeat (3000) tick(1'b1);

    a_wr_req = 1'b0; b_wr_req = 1'b0; a_rd_req = 1'b0; b_rd_req = 1'b0; clr_start = 1'b0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
